// File: rtl/axi_lite_sram_slave.sv
`timescale 1ns/1ps
// AXI4-lite SRAM slave with byte-strobed writes and out-of-range error responses; read and write sides run independently.
// Latency: read data RD_LAT cycles after the AR handshake; write response WR_LAT cycles after both AW and W are held.
// Backpressure: one read and one write in flight; each response is held until its ready while the request readys stay low.
module axi_lite_sram_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                RD_LAT    = 1,
    parameter int                WR_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                araddr_valid,
    output logic                araddr_ready,
    input  logic [ADDR_W-1:0]   araddr_addr,
    output logic                raddr_valid,
    input  logic                raddr_ready,
    output logic [DATA_W-1:0]   raddr_data,
    output logic                raddr_resp,
    input  logic                awaddr_valid,
    output logic                awaddr_ready,
    input  logic [ADDR_W-1:0]   awaddr_addr,
    input  logic                wdata_valid,
    output logic                wdata_ready,
    input  logic [DATA_W-1:0]   wdata_data,
    input  logic [DATA_W/8-1:0] wdata_strb,
    output logic                bresp_valid,
    input  logic                bresp_ready,
    output logic                bresp_resp
);

    localparam int                BYTES   = DATA_W / 8;
    localparam int                OFF_W   = $clog2(BYTES);
    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [3:0]        RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0]        WR_LOAD = 4'(WR_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // Low during reset and for the edge that releases it, so readys only rise after the first edge with rst high.
    logic run_q;

    r_state_t          r_state, r_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_resp;
    logic              ar_hs, r_sample;

    w_state_t          w_state, w_next;
    logic [3:0]        w_cnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [BYTES-1:0]  w_strb;
    logic              aw_held, w_held, b_resp;
    logic              aw_hs, w_hs, w_commit;

    // Address lies inside the window [BASE_ADDR, BASE_ADDR + DEPTH words); low byte-offset bits are ignored.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> OFF_W) < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off[OFF_W +: IDX_W];
    endfunction

    // Track whether reset has been released for at least one edge.
    always_ff @(posedge clk) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    // Read FSM next state and registered-state decode of the read handshake signals.
    always_comb begin
        r_next       = r_state;
        araddr_ready = 1'b0;
        raddr_valid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                araddr_ready = run_q;
                if (araddr_valid && run_q) r_next = R_WAIT;
            end
            R_WAIT: begin
                if (r_cnt == 4'd0) r_next = R_RESP;
            end
            R_RESP: begin
                raddr_valid = 1'b1;
                if (raddr_ready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs    = araddr_valid && araddr_ready;
    assign r_sample = (r_state == R_WAIT) && (r_cnt == 4'd0);

    // Read state, latency countdown, and the memory sample that is held through the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_data  <= '0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_addr <= araddr_addr;
                r_cnt  <= RD_LOAD;
            end else if ((r_state == R_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_sample) begin
                if (addr_ok(r_addr)) begin
                    r_data <= mem[addr_idx(r_addr)];
                    r_resp <= 1'b0;
                end else begin
                    r_data <= '0;
                    r_resp <= 1'b1;
                end
            end
        end
    end

    assign raddr_data = r_data;
    assign raddr_resp = r_resp;

    // Write FSM next state; AW and W each accept once per transaction, in any order.
    always_comb begin
        w_next       = w_state;
        awaddr_ready = 1'b0;
        wdata_ready  = 1'b0;
        bresp_valid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awaddr_ready = run_q && !aw_held;
                wdata_ready  = run_q && !w_held;
                if ((aw_held || (awaddr_valid && run_q)) && (w_held || (wdata_valid && run_q)))
                    w_next = W_WAIT;
            end
            W_WAIT: begin
                if (w_cnt == 4'd0) w_next = W_RESP;
            end
            W_RESP: begin
                bresp_valid = 1'b1;
                if (bresp_ready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs    = awaddr_valid && awaddr_ready;
    assign w_hs     = wdata_valid && wdata_ready;
    assign w_commit = (w_state == W_WAIT) && (w_cnt == 4'd0);

    // Write state, per-channel payload latches, latency countdown and response code.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_cnt   <= 4'd0;
            w_addr  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            b_resp  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_addr  <= awaddr_addr;
                aw_held <= 1'b1;
            end
            if (w_hs) begin
                w_data <= wdata_data;
                w_strb <= wdata_strb;
                w_held <= 1'b1;
            end
            if ((w_state == W_IDLE) && (w_next == W_WAIT)) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                w_cnt   <= WR_LOAD;
            end else if ((w_state == W_WAIT) && (w_cnt != 4'd0)) begin
                w_cnt <= w_cnt - 4'd1;
            end
            if (w_commit) b_resp <= !addr_ok(w_addr);
        end
    end

    assign bresp_resp = b_resp;

    // Byte-strobed commit; contents survive reset and a reset on the commit edge cancels the write.
    always_ff @(posedge clk) begin
        if (rst && w_commit && addr_ok(w_addr)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_strb[b]) mem[addr_idx(w_addr)][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
`timescale 1ns/1ps
// Bench for axi_lite_sram_slave: two instances (latency 1/1 and 4/3) driven by per-scenario tasks.
// Expected data comes from a word-array reference model updated from the address/strobe rules.
// Every wait on the DUT is bounded; a global watchdog ends the run if something hangs.
module tb_axi_lite_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;
    localparam int          WIN   = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        arv [2];
    logic        arr [2];
    logic [31:0] ara [2];
    logic        rv  [2];
    logic        rr  [2];
    logic [31:0] rd  [2];
    logic        rrs [2];
    logic        awv [2];
    logic        awr [2];
    logic [31:0] awa [2];
    logic        wv  [2];
    logic        wr  [2];
    logic [31:0] wd  [2];
    logic [3:0]  ws  [2];
    logic        bv  [2];
    logic        br  [2];
    logic        brs [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [2][WORDS];

    always #5 clk = ~clk;

    axi_lite_sram_slave dut_a (
        .clk(clk), .rst(rst),
        .araddr_valid(arv[0]), .araddr_ready(arr[0]), .araddr_addr(ara[0]),
        .raddr_valid(rv[0]), .raddr_ready(rr[0]), .raddr_data(rd[0]), .raddr_resp(rrs[0]),
        .awaddr_valid(awv[0]), .awaddr_ready(awr[0]), .awaddr_addr(awa[0]),
        .wdata_valid(wv[0]), .wdata_ready(wr[0]), .wdata_data(wd[0]), .wdata_strb(ws[0]),
        .bresp_valid(bv[0]), .bresp_ready(br[0]), .bresp_resp(brs[0])
    );

    axi_lite_sram_slave #(.RD_LAT(4), .WR_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .araddr_valid(arv[1]), .araddr_ready(arr[1]), .araddr_addr(ara[1]),
        .raddr_valid(rv[1]), .raddr_ready(rr[1]), .raddr_data(rd[1]), .raddr_resp(rrs[1]),
        .awaddr_valid(awv[1]), .awaddr_ready(awr[1]), .awaddr_addr(awa[1]),
        .wdata_valid(wv[1]), .wdata_ready(wr[1]), .wdata_data(wd[1]), .wdata_strb(ws[1]),
        .bresp_valid(bv[1]), .bresp_ready(br[1]), .bresp_resp(brs[1])
    );

    // ---------------- reference model ----------------
    function automatic int rd_lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int wr_lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < WORDS);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
        return res;
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] nw, input logic [3:0] strb);
        if (in_range(a)) ref_mem[d][word_of(a)] = merge(ref_mem[d][word_of(a)], nw, strb);
    endtask

    // ---------------- bus transaction drivers (return observations only) ----------------
    task automatic do_read(input int d, input logic [31:0] addr, input int stall,
                           output logic [31:0] data, output logic resp, output int lat,
                           output bit stable, output bit back);
        int n;
        arv[d] = 1'b1;
        ara[d] = addr;
        n = 0;
        while (!arr[d] && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arv[d] = 1'b0;
        lat = 0;
        while (!rv[d] && lat < 50) begin @(posedge clk); #1; lat++; end
        data   = rd[d];
        resp   = rrs[d];
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (rv[d] !== 1'b1 || rd[d] !== data || rrs[d] !== resp) stable = 1'b0;
        end
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0;
        back = arr[d] && !rv[d];
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int t_aw, input int t_w, input int bstall,
                            output logic resp, output int lat, output bit drop_ok,
                            output bit stable, output bit back);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 1'b0;
        w_done  = 1'b0;
        drop_ok = 1'b1;
        cyc     = 0;
        awa[d]  = addr;
        wd[d]   = data;
        ws[d]   = strb;
        while (!(aw_done && w_done) && cyc < 60) begin
            awv[d] = (cyc >= t_aw) && !aw_done;
            wv[d]  = (cyc >= t_w) && !w_done;
            aw_hs  = awv[d] && awr[d];
            w_hs   = wv[d] && wr[d];
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
            if (aw_done && !w_done && awr[d] !== 1'b0) drop_ok = 1'b0;
            if (w_done && !aw_done && wr[d] !== 1'b0) drop_ok = 1'b0;
        end
        awv[d] = 1'b0;
        wv[d]  = 1'b0;
        lat = 0;
        while (!bv[d] && lat < 50) begin @(posedge clk); #1; lat++; end
        resp   = brs[d];
        stable = 1'b1;
        for (int i = 0; i < bstall; i++) begin
            @(posedge clk); #1;
            if (bv[d] !== 1'b1 || brs[d] !== resp) stable = 1'b0;
        end
        br[d] = 1'b1;
        @(posedge clk); #1;
        br[d] = 1'b0;
        back = awr[d] && wr[d] && !bv[d];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({arr[d], rv[d], rd[d], rrs[d], awr[d], wr[d], bv[d], brs[d]} !== 39'd0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got %h, expected 0", d,
                         {arr[d], rv[d], rd[d], rrs[d], awr[d], wr[d], bv[d], brs[d]});
            end
        end
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({arr[d], awr[d], wr[d]} !== 3'b000) begin
                failures++;
                $display("FAIL ready_before_release_edge dut%0d: got %b, expected 000", d, {arr[d], awr[d], wr[d]});
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({arr[d], awr[d], wr[d], rv[d], bv[d]} !== 5'b11100) begin
                failures++;
                $display("FAIL ready_after_release dut%0d: got %b, expected 11100", d,
                         {arr[d], awr[d], wr[d], rv[d], bv[d]});
            end
        end
    endtask

    task automatic test_init();
        logic resp;
        logic [31:0] v;
        int lat;
        bit dok, stb, back;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < WIN; w++) begin
                v = $urandom;
                do_write(d, BASE + 32'(4 * w), v, 4'hF, 0, 0, 0, resp, lat, dok, stb, back);
                model_write(d, BASE + 32'(4 * w), v, 4'hF);
                checks++;
                if (resp !== 1'b0 || lat != wr_lat(d)) begin
                    failures++;
                    $display("FAIL init_write dut%0d w%0d: got resp=%b lat=%0d, expected resp=0 lat=%0d", d, w, resp, lat, wr_lat(d));
                end
            end
        end
    endtask

    task automatic test_basic();
        logic resp;
        logic [31:0] data;
        int lat;
        bit dok, stb, back;
        do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, lat, dok, stb, back);
        model_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (resp !== 1'b0 || lat != 1 || !back) begin
            failures++;
            $display("FAIL basic_write: got resp=%b lat=%0d back=%b, expected resp=0 lat=1 back=1", resp, lat, back);
        end
        do_read(0, 32'h8000_0010, 0, data, resp, lat, stb, back);
        checks++;
        if (data !== 32'hDEAD_BEEF || resp !== 1'b0 || lat != 1 || !back) begin
            failures++;
            $display("FAIL basic_read: got data=%h resp=%b lat=%0d back=%b, expected deadbeef 0 1 1", data, resp, lat, back);
        end
        do_read(0, 32'h8000_0013, 0, data, resp, lat, stb, back);
        checks++;
        if (data !== 32'hDEAD_BEEF || resp !== 1'b0) begin
            failures++;
            $display("FAIL unaligned_read: got data=%h resp=%b, expected deadbeef 0", data, resp);
        end
    endtask

    task automatic test_latency_stall();
        logic resp;
        logic [31:0] data, v;
        int lat;
        bit dok, stb, back;
        v = $urandom;
        do_write(1, 32'h8000_0020, v, 4'hF, 0, 2, 3, resp, lat, dok, stb, back);
        model_write(1, 32'h8000_0020, v, 4'hF);
        checks++;
        if (resp !== 1'b0 || lat != 3 || !dok || !stb || !back) begin
            failures++;
            $display("FAIL wlat3: got resp=%b lat=%0d drop=%b stable=%b back=%b, expected 0 3 1 1 1", resp, lat, dok, stb, back);
        end
        do_read(1, 32'h8000_0020, 5, data, resp, lat, stb, back);
        checks++;
        if (data !== v || resp !== 1'b0 || lat != 4 || !stb || !back) begin
            failures++;
            $display("FAIL rlat4_stall: got data=%h lat=%0d stable=%b back=%b, expected %h 4 1 1", data, lat, stb, back, v);
        end
        do_write(0, 32'h8000_0024, v, 4'hF, 3, 0, 0, resp, lat, dok, stb, back);
        model_write(0, 32'h8000_0024, v, 4'hF);
        checks++;
        if (resp !== 1'b0 || lat != 1 || !dok) begin
            failures++;
            $display("FAIL wlat1_w_first: got resp=%b lat=%0d drop=%b, expected 0 1 1", resp, lat, dok);
        end
    endtask

    task automatic test_strobe_order();
        logic resp;
        logic [31:0] data, v;
        logic [3:0] s;
        int lat;
        bit dok, stb, back;
        for (int d = 0; d < 2; d++) begin
            do_write(d, 32'h8000_0040, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, lat, dok, stb, back);
            model_write(d, 32'h8000_0040, 32'hFFFF_FFFF, 4'hF);
            do_write(d, 32'h8000_0040, 32'h1122_3344, 4'b0101, 2, 0, 0, resp, lat, dok, stb, back);
            model_write(d, 32'h8000_0040, 32'h1122_3344, 4'b0101);
            checks++;
            if (resp !== 1'b0 || lat != wr_lat(d) || !dok) begin
                failures++;
                $display("FAIL w_before_aw dut%0d: got resp=%b lat=%0d drop=%b, expected 0 %0d 1", d, resp, lat, dok, wr_lat(d));
            end
            do_read(d, 32'h8000_0040, 0, data, resp, lat, stb, back);
            checks++;
            if (data !== 32'hFF22_FF44) begin
                failures++;
                $display("FAIL strobe_merge dut%0d: got %h, expected ff22ff44", d, data);
            end
            v = $urandom;
            s = 4'($urandom);
            do_write(d, 32'h8000_0044, v, s, 0, 3, 0, resp, lat, dok, stb, back);
            model_write(d, 32'h8000_0044, v, s);
            do_read(d, 32'h8000_0044, 1, data, resp, lat, stb, back);
            checks++;
            if (data !== ref_mem[d][17] || !dok) begin
                failures++;
                $display("FAIL aw_first_strobe dut%0d: got %h drop=%b, expected %h drop=1", d, data, dok, ref_mem[d][17]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic resp;
        logic [31:0] data, v;
        int lat;
        bit dok, stb, back;
        for (int d = 0; d < 2; d++) begin
            do_read(d, 32'h7FFF_FFFC, 0, data, resp, lat, stb, back);
            checks++;
            if (data !== 32'd0 || resp !== 1'b1 || lat != rd_lat(d)) begin
                failures++;
                $display("FAIL read_below_base dut%0d: got data=%h resp=%b lat=%0d, expected 0 1 %0d", d, data, resp, lat, rd_lat(d));
            end
            do_read(d, 32'h8000_4000, 0, data, resp, lat, stb, back);
            checks++;
            if (data !== 32'd0 || resp !== 1'b1) begin
                failures++;
                $display("FAIL read_past_end dut%0d: got data=%h resp=%b, expected 0 1", d, data, resp);
            end
            v = $urandom;
            do_write(d, 32'h8000_4000, v, 4'hF, 0, 0, 0, resp, lat, dok, stb, back);
            model_write(d, 32'h8000_4000, v, 4'hF);
            checks++;
            if (resp !== 1'b1 || lat != wr_lat(d)) begin
                failures++;
                $display("FAIL write_past_end dut%0d: got resp=%b lat=%0d, expected 1 %0d", d, resp, lat, wr_lat(d));
            end
            do_read(d, BASE, 0, data, resp, lat, stb, back);
            checks++;
            if (data !== ref_mem[d][0] || resp !== 1'b0) begin
                failures++;
                $display("FAIL word0_untouched dut%0d: got %h, expected %h", d, data, ref_mem[d][0]);
            end
            do_write(d, 32'h8000_3FFC, v, 4'hF, 0, 0, 0, resp, lat, dok, stb, back);
            model_write(d, 32'h8000_3FFC, v, 4'hF);
            do_read(d, 32'h8000_3FFC, 0, data, resp, lat, stb, back);
            checks++;
            if (data !== v || resp !== 1'b0) begin
                failures++;
                $display("FAIL last_word dut%0d: got data=%h resp=%b, expected %h 0", d, data, resp, v);
            end
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] old_v, new_v, data, got;
        logic resp, got_b;
        int lat, dly, n;
        bit stb, back;
        for (int d = 0; d < 2; d++) begin
            old_v = ref_mem[d][8];
            new_v = ~old_v ^ 32'h0F0F_0000;
            dly   = rd_lat(d) - wr_lat(d);
            ara[d] = BASE + 32'd32;
            awa[d] = BASE + 32'd32;
            wd[d]  = new_v;
            ws[d]  = 4'hF;
            arv[d] = 1'b1;
            for (int c = 0; c <= dly; c++) begin
                if (c == dly) begin awv[d] = 1'b1; wv[d] = 1'b1; end
                @(posedge clk); #1;
                arv[d] = 1'b0;
                if (c == dly) begin awv[d] = 1'b0; wv[d] = 1'b0; end
            end
            n = 0;
            while (!(rv[d] && bv[d]) && n < 50) begin @(posedge clk); #1; n++; end
            got   = rd[d];
            got_b = brs[d];
            rr[d] = 1'b1;
            br[d] = 1'b1;
            @(posedge clk); #1;
            rr[d] = 1'b0;
            br[d] = 1'b0;
            model_write(d, BASE + 32'd32, new_v, 4'hF);
            checks++;
            if (got !== old_v || got_b !== 1'b0 || n >= 50) begin
                failures++;
                $display("FAIL same_edge_old dut%0d: got %h bresp=%b, expected %h 0", d, got, got_b, old_v);
            end
            do_read(d, BASE + 32'd32, 0, data, resp, lat, stb, back);
            checks++;
            if (data !== new_v) begin
                failures++;
                $display("FAIL same_edge_new dut%0d: got %h, expected %h", d, data, new_v);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] data;
        logic resp;
        int lat;
        bit stb, back, quiet;
        for (int d = 0; d < 2; d++) begin
            ara[d] = BASE + 32'd48;
            awa[d] = BASE + 32'd48;
            wd[d]  = ~ref_mem[d][12];
            ws[d]  = 4'hF;
            arv[d] = 1'b1;
            awv[d] = 1'b1;
            wv[d]  = 1'b1;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin arv[d] = 1'b0; awv[d] = 1'b0; wv[d] = 1'b0; end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({arr[d], rv[d], rd[d], rrs[d], awr[d], wr[d], bv[d], brs[d]} !== 39'd0) begin
                failures++;
                $display("FAIL midflight_reset_outputs dut%0d: got %h, expected 0", d,
                         {arr[d], rv[d], rd[d], rrs[d], awr[d], wr[d], bv[d], brs[d]});
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({arr[d], awr[d], wr[d]} !== 3'b111) begin
                failures++;
                $display("FAIL midflight_readys dut%0d: got %b, expected 111", d, {arr[d], awr[d], wr[d]});
            end
        end
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rv[0] || rv[1] || bv[0] || bv[1]) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL midflight_dropped: got a late valid, expected none");
        end
        for (int d = 0; d < 2; d++) begin
            do_read(d, BASE + 32'd48, 0, data, resp, lat, stb, back);
            checks++;
            if (data !== ref_mem[d][12] || resp !== 1'b0) begin
                failures++;
                $display("FAIL midflight_no_commit dut%0d: got %h, expected %h", d, data, ref_mem[d][12]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] bad [4];
        logic [31:0] wa, ra, wval, exp_d, r_data;
        logic [3:0]  st;
        logic        exp_rr, exp_b, r_resp, b_resp;
        int          wi, ri, wlat, rlat;
        bit          dok, wstb, wback, rstb, rback;
        bad[0] = 32'h7FFF_FFFC;
        bad[1] = 32'h8000_4000;
        bad[2] = 32'h0000_0000;
        bad[3] = 32'hFFFF_FFF0;
        for (int d = 0; d < 2; d++) begin
            for (int it = 0; it < 25; it++) begin
                wi = $urandom_range(WIN - 1);
                ri = (wi + 1 + $urandom_range(WIN - 2)) % WIN;
                wa = BASE + 32'(4 * wi) + 32'($urandom_range(3));
                ra = BASE + 32'(4 * ri) + 32'($urandom_range(3));
                if ($urandom_range(7) == 0) wa = bad[$urandom_range(3)];
                if ($urandom_range(7) == 0) ra = bad[$urandom_range(3)];
                wval   = $urandom;
                st     = 4'($urandom);
                exp_rr = !in_range(ra);
                exp_d  = exp_rr ? 32'd0 : ref_mem[d][word_of(ra)];
                exp_b  = !in_range(wa);
                fork
                    do_write(d, wa, wval, st, $urandom_range(3), $urandom_range(3), $urandom_range(2),
                             b_resp, wlat, dok, wstb, wback);
                    do_read(d, ra, $urandom_range(3), r_data, r_resp, rlat, rstb, rback);
                join
                model_write(d, wa, wval, st);
                checks++;
                if (r_data !== exp_d || r_resp !== exp_rr || rlat != rd_lat(d) || !rstb) begin
                    failures++;
                    $display("FAIL rand_read dut%0d it%0d addr=%h: got %h/%b lat=%0d, expected %h/%b lat=%0d",
                             d, it, ra, r_data, r_resp, rlat, exp_d, exp_rr, rd_lat(d));
                end
                checks++;
                if (b_resp !== exp_b || wlat != wr_lat(d) || !dok || !wstb) begin
                    failures++;
                    $display("FAIL rand_write dut%0d it%0d addr=%h: got resp=%b lat=%0d, expected resp=%b lat=%0d",
                             d, it, wa, b_resp, wlat, exp_b, wr_lat(d));
                end
            end
            for (int w = 0; w < WIN; w++) begin
                do_read(d, BASE + 32'(4 * w), 0, r_data, r_resp, rlat, rstb, rback);
                checks++;
                if (r_data !== ref_mem[d][w]) begin
                    failures++;
                    $display("FAIL rand_sweep dut%0d w%0d: got %h, expected %h", d, w, r_data, ref_mem[d][w]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            arv[d] = 1'b0; ara[d] = '0; rr[d] = 1'b0;
            awv[d] = 1'b0; awa[d] = '0; wv[d] = 1'b0; wd[d] = '0; ws[d] = '0; br[d] = 1'b0;
        end
        test_reset();
        test_init();
        test_basic();
        test_latency_stall();
        test_strobe_order();
        test_out_of_range();
        test_same_edge();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- Parametrised AXI4-lite slave memory model, one clock, serving the core's fetch/LSU bus in simulation and FPGA builds.
- Successor to the current fixed read-only fetch port: adds a write channel with byte strobes, configurable data width, depth, base address and per-channel latency, plus error response on out-of-range access.
- Sits between the core's AXI master port and the top-level harness.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; 32 or 64.
- DEPTH, 4096, memory depth in DATA_W words; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR handshake to raddr_valid; range 1..15.
- WR_LAT, 1, cycles from both AW and W latched to bresp_valid; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active low.
- araddr_valid  in  1  read address valid.
- araddr_ready  out  1  read address ready.
- araddr_addr  in  ADDR_W  read byte address.
- raddr_valid  out  1  read data valid.
- raddr_ready  in  1  read data ready.
- raddr_data  out  DATA_W  read data.
- raddr_resp  out  1  0 = OK, 1 = error.
- awaddr_valid  in  1  write address valid.
- awaddr_ready  out  1  write address ready.
- awaddr_addr  in  ADDR_W  write byte address.
- wdata_valid  in  1  write data valid.
- wdata_ready  out  1  write data ready.
- wdata_data  in  DATA_W  write data.
- wdata_strb  in  DATA_W/8  byte enables.
- bresp_valid  out  1  write response valid.
- bresp_ready  in  1  write response ready.
- bresp_resp  out  1  0 = OK, 1 = error.

Behaviour:
- Reset (rst == 0 at a clk edge): all outputs are 0 (every ready, every valid, data, resp).
  - Both FSMs go to IDLE and the latency counters clear.
  - In-flight transactions are dropped; uncommitted writes are never applied.
  - Memory contents are not reset.
  - Readys rise on the first edge with rst == 1.
- Indexing: word index = (addr - BASE_ADDR) >> log2(DATA_W/8).
  - Low address bits are ignored; there is no misalignment error.
  - Out of range (addr < BASE_ADDR or index >= DEPTH): resp = 1, raddr_data = 0, write suppressed.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP.
  - R_IDLE: araddr_ready = 1; handshake (araddr_valid & araddr_ready) latches the address and loads the counter with RD_LAT-1.
  - R_WAIT: araddr_ready = 0; counter decrements; at 0 the FSM samples memory into raddr_data/resp and enters R_RESP.
  - raddr_valid therefore rises exactly RD_LAT cycles after the AR handshake edge.
  - R_RESP: raddr_valid = 1; data/resp held stable until raddr_ready; on the handshake go to R_IDLE.
  - araddr_ready returns 1 the next cycle; at most one outstanding read.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP.
  - W_IDLE: awaddr_ready and wdata_ready are independent. Each channel drops its ready after its own handshake and latches its payload.
  - AW and W may arrive in either order or the same cycle.
  - When both are latched: counter loads WR_LAT-1 and the FSM enters W_WAIT.
  - W_WAIT: at counter 0 the write commits, byte-wise per wdata_strb; strb = 0 commits nothing but still responds OK. The FSM then enters W_RESP.
  - W_RESP: bresp_valid = 1, resp held until bresp_ready; then W_IDLE, with both readys high the next cycle.
- Read/write same word, same edge: memory is sampled before the write updates it (read-before-write), so the read returns old data.
- Read and write FSMs run fully concurrently; no arbitration.
- Valid/ready rules:
  - Outputs never depend combinationally on inputs; all are registered.
  - A raised valid is never withdrawn before its handshake.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to 0x8000_0010 (strb 4'hF), then read 0x8000_0010 with RD_LAT=1 -> bresp_resp=0; raddr_valid one cycle after AR handshake; data 32'hDEAD_BEEF, resp 0.
- RD_LAT=4, WR_LAT=3; hold raddr_ready=0 for 5 cycles -> raddr_valid at +4 cycles, data stable throughout stall; bresp_valid 3 cycles after second of AW/W latched.
- W presented 2 cycles before AW, strb 4'b0101, data 32'h1122_3344 over 32'hFFFF_FFFF -> read returns 32'hFF22_FF44.
- Read 0x7FFF_FFFC and 0x8000_4000 (DEPTH=4096, DATA_W=32) -> resp=1, data 0; write to 0x8000_4000 -> bresp_resp=1, word 0 unchanged.
- Read and write commit to the same word on the same edge -> read returns pre-write value; the following read returns the new value.
- rst low during R_WAIT and W_WAIT -> next cycle all valids 0, no commit; after release, readys 1 and the earlier read of the target word returns the old data.
